ecc_operand_loader: RTL and testbench

Parametrised digit-serial operand loader and result unloader for the ECC scalar-multiplication datapath. Assembles N_CH operands (prime, Px, Py, a, k by default) from DIGIT_W-bit digits delivered MSB-first over a valid/ready handshake, pulses a start strobe to the Control/GFAU core, then serialises the core's WORD_W-bit result back out digit by digit. It sits between the chip pins and Control.

---
 rtl/ecc_operand_loader.sv | 129 ++++++++++++
 tb/tb_ecc_operand_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_operand_loader.sv
// rtl/ecc_operand_loader.sv - digit-serial ECC operand loader and result unloader (optional abort: LOADER_ABORT_EN)
module ecc_operand_loader #(
    parameter int WORD_W  = 32,
    parameter int DIGIT_W = 4,
    parameter int N_CH    = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    input  logic [N_CH*DIGIT_W-1:0]   i_digits,
    output logic                      o_ready,
    output logic [N_CH*WORD_W-1:0]    o_words,
    output logic                      o_start,
    input  logic                      i_core_done,
    input  logic [WORD_W-1:0]         i_result,
    output logic                      o_res_valid,
    output logic [DIGIT_W-1:0]        o_res_digit,
    input  logic                      i_res_ready,
    input  logic                      i_abort
);

    // WORD_W must be an exact multiple of DIGIT_W; one beat carries one digit per channel.
    localparam int BEATS = WORD_W / DIGIT_W;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_BUSY,
        S_UNLOAD
    } state_t;

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic [N_CH*WORD_W-1:0]    words_q;
    logic [N_CH*WORD_W-1:0]    words_shifted;
    logic [WORD_W-1:0]         result_q;
    logic                      start_q;
    logic                      res_valid_q;
    logic                      beat_acc;
    logic                      abort_req;

    assign o_ready     = (state == S_IDLE) || (state == S_LOAD);
    assign o_words     = words_q;
    assign o_start     = start_q;
    assign o_res_valid = res_valid_q;
    assign o_res_digit = result_q[WORD_W-1 -: DIGIT_W];

    assign beat_acc = i_valid && o_ready;

`ifdef LOADER_ABORT_EN
    // Abort only has meaning while a transfer is in flight; IDLE and BUSY ignore it.
    assign abort_req = i_abort && ((state == S_LOAD) || (state == S_UNLOAD));
`else
    logic unused_abort;
    assign unused_abort = i_abort;
    assign abort_req    = 1'b0;
`endif

    // Next word per channel: drop the top digit, append the new digit at the bottom (MSB-first assembly).
    always_comb begin
        words_shifted = '0;
        for (int c = 0; c < N_CH; c++) begin
            words_shifted[c*WORD_W +: WORD_W] =
                WORD_W'({words_q[c*WORD_W +: WORD_W], i_digits[c*DIGIT_W +: DIGIT_W]});
        end
    end

    // Control FSM: load beats, pulse start, wait for core, stream the result back out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            words_q     <= '0;
            result_q    <= '0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (abort_req) begin
                // Abort takes priority over a coincident last beat or last handshake.
                state       <= S_IDLE;
                cnt         <= '0;
                res_valid_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_LOAD: begin
                        if (beat_acc) begin
                            words_q <= words_shifted;
                            if (cnt == LAST_CNT) begin
                                cnt     <= '0;
                                start_q <= 1'b1;
                                state   <= S_BUSY;
                            end else begin
                                cnt   <= cnt + 1'b1;
                                state <= S_LOAD;
                            end
                        end
                    end
                    S_BUSY: begin
                        if (i_core_done) begin
                            result_q    <= i_result;
                            res_valid_q <= 1'b1;
                            state       <= S_UNLOAD;
                        end
                    end
                    S_UNLOAD: begin
                        if (i_res_ready) begin
                            result_q <= result_q << DIGIT_W;
                            if (cnt == LAST_CNT) begin
                                cnt         <= '0;
                                res_valid_q <= 1'b0;
                                state       <= S_IDLE;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ecc_operand_loader.sv
// tb/tb_ecc_operand_loader.sv - scoreboard bench for ecc_operand_loader
module tb_ecc_operand_loader;

    localparam int WORD_W  = 32;
    localparam int DIGIT_W = 4;
    localparam int N_CH    = 5;
    localparam int BEATS   = WORD_W / DIGIT_W;

    logic                    i_clk = 1'b0;
    logic                    i_rst_n;
    logic                    i_valid;
    logic [N_CH*DIGIT_W-1:0] i_digits;
    logic                    o_ready;
    logic [N_CH*WORD_W-1:0]  o_words;
    logic                    o_start;
    logic                    i_core_done;
    logic [WORD_W-1:0]       i_result;
    logic                    o_res_valid;
    logic [DIGIT_W-1:0]      o_res_digit;
    logic                    i_res_ready;
    logic                    i_abort;

    ecc_operand_loader #(
        .WORD_W (WORD_W),
        .DIGIT_W(DIGIT_W),
        .N_CH   (N_CH)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .i_digits   (i_digits),
        .o_ready    (o_ready),
        .o_words    (o_words),
        .o_start    (o_start),
        .i_core_done(i_core_done),
        .i_result   (i_result),
        .o_res_valid(o_res_valid),
        .o_res_digit(o_res_digit),
        .i_res_ready(i_res_ready),
        .i_abort    (i_abort)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [N_CH*WORD_W-1:0] words;
        int                     start_cyc;
    } exp_t;

    exp_t             wq[$];
    logic [DIGIT_W-1:0] dq[$];
    bit               prev_start = 1'b0;

    // channel c at [c*32 +: 32]
    localparam logic [N_CH*WORD_W-1:0] VEC_A =
        {32'h12345678, 32'h00000003, 32'h00000002, 32'h00000001, 32'hFFFFFFFD};
    localparam logic [N_CH*WORD_W-1:0] VEC_B =
        {32'hFFFFFFFF, 32'h00000000, 32'hCAFEBABE, 32'h0F0F0F0F, 32'h89ABCDEF};
    localparam logic [N_CH*WORD_W-1:0] VEC_ONES =
        {32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111};

    task automatic chk(input string name, input logic [N_CH*WORD_W-1:0] act,
                       input logic [N_CH*WORD_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    always @(negedge i_clk) begin
        if (i_rst_n === 1'b1) begin
            if (o_start === 1'b1) begin
                chk("start_width", prev_start, 0);
                if (wq.size() == 0) begin
                    chk("start_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = wq.pop_front();
                    chk("start_cycle", cyc, e.start_cyc);
                    chk("words", o_words, e.words);
                end
            end
            if (o_res_valid === 1'b1) begin
                if (dq.size() == 0) begin
                    chk("digit_unexpected", 1, 0);
                end else if (i_res_ready === 1'b1) begin
                    chk("res_digit", o_res_digit, dq.pop_front());
                end else begin
                    chk("res_digit_hold", o_res_digit, dq[0]);
                end
            end
        end
        prev_start = (o_start === 1'b1);
    end

    task automatic drive_beat(input logic [N_CH*WORD_W-1:0] wv, input int b);
        i_valid = 1'b1;
        for (int c = 0; c < N_CH; c++)
            i_digits[c*DIGIT_W +: DIGIT_W] = wv[c*WORD_W + WORD_W - DIGIT_W - DIGIT_W*b +: DIGIT_W];
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic do_load(input logic [N_CH*WORD_W-1:0] wv, input logic [7:0] gaps,
                           input int done_beat);
        exp_t e;
        int   ng = 0;
        for (int b = 0; b < BEATS; b++) if (gaps[b]) ng++;
        e.words     = wv;
        e.start_cyc = cyc + BEATS + ng;
        wq.push_back(e);
        for (int b = 0; b < BEATS; b++) begin
            if (gaps[b]) begin
                i_valid  = 1'b0;
                i_digits = N_CH*DIGIT_W'($urandom);
                @(posedge i_clk);
                #1;
            end
            if (b == done_beat) begin
                i_core_done = 1'b1;
                i_result    = 32'hBAD0BAD0;
            end
            drive_beat(wv, b);
            i_core_done = 1'b0;
        end
    endtask

    task automatic do_unload(input logic [WORD_W-1:0] res, input bit toggle);
        int iters = 0;
        for (int i = 0; i < BEATS; i++) dq.push_back(res[WORD_W - DIGIT_W - DIGIT_W*i +: DIGIT_W]);
        i_core_done = 1'b1;
        i_result    = res;
        i_res_ready = 1'b0;
        @(posedge i_clk);
        #1;
        i_core_done = 1'b0;
        i_result    = 32'h0;
        chk("res_valid_rise", o_res_valid, 1);
        for (int k = 0; k < 40; k++) begin
            i_res_ready = toggle ? ((k % 2) == 0) : 1'b1;
            @(posedge i_clk);
            #1;
            iters++;
            if (o_res_valid !== 1'b1) break;
        end
        i_res_ready = 1'b0;
        chk("unload_cycles", iters, toggle ? 15 : 8);
        chk("unload_valid_drop", o_res_valid, 0);
        chk("unload_ready_back", o_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        i_rst_n     = 1'b0;
        i_valid     = 1'b0;
        i_digits    = '0;
        i_core_done = 1'b0;
        i_result    = '0;
        i_res_ready = 1'b0;
        i_abort     = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_words", o_words, 0);
        chk("rst_start", o_start, 0);
        chk("rst_res_valid", o_res_valid, 0);
        chk("rst_res_digit", o_res_digit, 0);
        i_rst_n = 1'b1;
        #1;
        chk("rst_ready", o_ready, 1);

        // plain load then full-rate unload
        do_load(VEC_A, 8'h00, -1);
        do_unload(32'hDEADBEEF, 1'b0);

        // stalled load with stray core_done, then throttled unload
        do_load(VEC_A, 8'b0010_0100, 1);
        chk("no_unload_after_stray_done", o_res_valid, 0);
        do_unload(32'hA5C31E70, 1'b1);

        // reset in the middle of a load
        for (int b = 0; b < 4; b++) drive_beat(VEC_B, b);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_words", o_words, 0);
        chk("midrst_start", o_start, 0);
        chk("midrst_res_valid", o_res_valid, 0);
        chk("midrst_res_digit", o_res_digit, 0);
        chk("midrst_ready", o_ready, 1);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        #1;
        do_load(VEC_B, 8'h00, -1);
        do_unload(32'h13579BDF, 1'b0);

        // abort at beat 5
`ifdef LOADER_ABORT_EN
        for (int b = 0; b < 4; b++) drive_beat(VEC_A, b);
        i_abort = 1'b1;
        drive_beat(VEC_A, 4);
        i_abort = 1'b0;
        chk("abort_ready", o_ready, 1);
        chk("abort_res_valid", o_res_valid, 0);
        repeat (3) @(posedge i_clk);
        #1;
        do_load(VEC_ONES, 8'h00, -1);
`else
        begin
            exp_t e;
            e.words     = VEC_A;
            e.start_cyc = cyc + BEATS;
            wq.push_back(e);
            for (int b = 0; b < 4; b++) drive_beat(VEC_A, b);
            i_abort = 1'b1;
            drive_beat(VEC_A, 4);
            i_abort = 1'b0;
            for (int b = 5; b < BEATS; b++) drive_beat(VEC_A, b);
        end
`endif
        do_unload(32'h2468ACE0, 1'b0);

        repeat (3) @(posedge i_clk);
        #1;
        chk("words_queue_drained", wq.size(), 0);
        chk("digit_queue_drained", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
